// File: rtl/uart_tx_frame.sv
// Purpose: FIFO-buffered UART transmitter with run-time baud divisor, parity mode and stop-bit count.
// Latency: a word accepted into an empty FIFO while idle is popped on the next edge; the start bit begins on that edge.
// Backpressure: s_ready = !full; frames go out back-to-back while the FIFO holds words.

// Small synchronous FIFO. Pointers carry an extra wrap bit, so full and empty need no separate flag.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = LVL_W'(wr_ptr - rd_ptr);
    assign pop_dat  = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage array: no reset needed, contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Pointer update; clearing both pointers discards every queued word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module uart_tx_frame #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16,
    parameter int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PAYLOAD_BITS-1:0] s_data,
    input  logic [DIV_W-1:0]        baud_div,
    input  logic [1:0]              parity_mode,
    input  logic                    stop2,
    output logic                    uart_txd,
    output logic                    busy,
    output logic                    tx_done,
    output logic [LVL_W-1:0]        fifo_level
);
    // Bit index only needs to reach PAYLOAD_BITS-1 (at most 8 for 9-bit payloads).
    localparam int BW = $clog2(PAYLOAD_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [DIV_W-1:0]        cnt;
    logic [BW-1:0]           bit_idx;
    logic                    stop_idx;

    // Frame configuration captured at pop so mid-frame input changes only affect the next frame.
    logic [DIV_W-1:0]        cfg_div;
    logic                    cfg_par_en;
    logic                    cfg_par_bit;
    logic                    cfg_stop2;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [PAYLOAD_BITS-1:0] fifo_dat;
    logic                    bit_end;
    logic                    last_stop_end;
    logic                    pop;
    logic                    data_xor;

    assign s_ready = !fifo_full;

    uart_tx_fifo #(
        .W     (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (s_valid),
        .push_dat (s_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Bit timing and pop decision: a new frame starts from IDLE or on the edge ending the last stop bit.
    always_comb begin
        bit_end       = (cnt == cfg_div);
        last_stop_end = (state == STOP) && bit_end && (!cfg_stop2 || stop_idx);
        pop           = !fifo_empty && ((state == IDLE) || last_stop_end);
        data_xor      = ^fifo_dat;
        busy          = (state != IDLE) || !fifo_empty;
    end

    // Frame sequencer: walks START/DATA/PARITY/STOP and drives the registered line and done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            shift_reg   <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            cfg_div     <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_bit <= 1'b0;
            cfg_stop2   <= 1'b0;
            uart_txd    <= 1'b1;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        uart_txd <= shift_reg[0];
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == BW'(PAYLOAD_BITS - 1)) begin
                            if (cfg_par_en) begin
                                state    <= PARITY;
                                uart_txd <= cfg_par_bit;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                uart_txd <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            uart_txd <= shift_reg[1];
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        uart_txd <= 1'b1;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (cfg_stop2 && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            tx_done  <= 1'b1;
                            state    <= IDLE;
                            uart_txd <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase

            // Pop overrides the case above so the next start bit follows the last stop bit with no gap.
            if (pop) begin
                state       <= START;
                shift_reg   <= fifo_dat;
                cnt         <= '0;
                cfg_div     <= baud_div;
                cfg_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                cfg_par_bit <= (parity_mode == 2'b10) ? ~data_xor : data_xor;
                cfg_stop2   <= stop2;
                uart_txd    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic [15:0] baud_div = 16'd9;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic       uart_txd;
    logic       busy;
    logic       tx_done;
    logic [4:0] fifo_level;

    int checks = 0;
    int errors = 0;
    logic [7:0] rw [17];

    uart_tx_frame dut (
        .clk         (clk),
        .resetn      (resetn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .uart_txd    (uart_txd),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word and hold it until taken; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        s_valid = 1'b0;
    endtask

    // Reference frame: start 0, data LSB first, optional parity from the count of ones, 1 or 2 stop bits,
    // each bit held div+1 cycles; tx_done must appear exactly one sample after the last stop cycle.
    task automatic check_frame(input logic [7:0] w, input int div, input logic [1:0] pm,
                               input logic s2, input string tag, output int waited);
        logic [12:0] bits;
        int nb;
        int ones;
        int bad;
        bits = '0;
        ones = $countones(w);
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = w[i];
            nb++;
        end
        if (pm == 2'b01) begin
            bits[nb] = (ones % 2 == 1);
            nb++;
        end else if (pm == 2'b10) begin
            bits[nb] = (ones % 2 == 0);
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (s2) begin
            bits[nb] = 1'b1;
            nb++;
        end
        waited = 0;
        while (uart_txd !== 1'b0 && waited < 3000) begin
            tick();
            waited++;
        end
        if (uart_txd !== 1'b0) begin
            chk({tag, "_start_timeout"}, uart_txd, 0);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            bad = 0;
            for (int c = 0; c <= div; c++) begin
                if (b != 0 || c != 0) tick();
                if (uart_txd !== bits[b]) bad++;
            end
            chk($sformatf("%s_bit%0d_bad_cycles", tag, b), bad, 0);
        end
        chk({tag, "_done_early"}, tx_done, 0);
        tick();
        chk({tag, "_done_pulse"}, tx_done, 1);
    endtask

    // Push nw random words at full rate while checking the emitted frames in order with no gaps.
    task automatic run_burst(input int nw, input string tag);
        for (int i = 0; i < nw; i++) rw[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < nw; i++) push(rw[i]);
            end
            begin
                int wt;
                for (int i = 0; i < nw; i++) begin
                    check_frame(rw[i], int'(baud_div), parity_mode, stop2,
                                $sformatf("%s_f%0d", tag, i), wt);
                    if (i > 0) chk($sformatf("%s_gap%0d", tag, i), wt, 0);
                end
            end
        join
        chk({tag, "_end_level"}, fifo_level, 0);
        chk({tag, "_end_busy"}, busy, 0);
    endtask

    initial begin
        int w;
        int cnt;
        int acc;

        // Reset held with s_valid asserted
        resetn  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        repeat (3) tick();
        chk("rst_txd", uart_txd, 1);
        chk("rst_ready", s_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        s_valid = 1'b0;
        resetn  = 1'b1;
        cnt = 0;
        repeat (50) begin
            tick();
            if (uart_txd === 1'b1 && fifo_level === 5'd0 && busy === 1'b0) cnt++;
        end
        chk("post_rst_idle_cycles", cnt, 50);

        // 8N1, divisor 9, 0xA5
        baud_div = 16'd9; parity_mode = 2'b00; stop2 = 1'b0;
        push(8'hA5);
        chk("8n1_level_after_push", fifo_level, 1);
        chk("8n1_txd_before_pop", uart_txd, 1);
        check_frame(8'hA5, 9, 2'b00, 1'b0, "8n1", w);
        chk("8n1_start_latency", w, 1);
        chk("8n1_busy_after", busy, 0);
        chk("8n1_level_after", fifo_level, 0);
        tick();
        chk("8n1_done_one_cycle", tx_done, 0);

        // Even parity, two stop bits, then odd parity
        parity_mode = 2'b01; stop2 = 1'b1;
        push(8'h07);
        check_frame(8'h07, 9, 2'b01, 1'b1, "even2", w);
        parity_mode = 2'b10;
        push(8'h07);
        check_frame(8'h07, 9, 2'b10, 1'b1, "odd2", w);
        tick();

        // FIFO full and back-to-back frames
        baud_div = 16'd1; parity_mode = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 17; i++) rw[i] = 8'($urandom);
        fork
            begin
                int n;
                acc = 0;
                n = 0;
                s_valid = 1'b1;
                s_data  = rw[0];
                while (acc < 17 && n < 100) begin
                    if (s_ready === 1'b1) acc++;
                    tick();
                    n++;
                    if (acc < 17) s_data = rw[acc];
                end
                chk("full_accept_cycles", n, 17);
                chk("full_ready_low", s_ready, 0);
                chk("full_level", fifo_level, 16);
                tick();
                tick();
                chk("full_level_held", fifo_level, 16);
                s_valid = 1'b0;
            end
            begin
                int wt;
                for (int i = 0; i < 17; i++) begin
                    check_frame(rw[i], 1, 2'b00, 1'b0, $sformatf("b2b_f%0d", i), wt);
                    if (i > 0) chk($sformatf("b2b_gap%0d", i), wt, 0);
                end
            end
        join
        chk("b2b_end_level", fifo_level, 0);
        chk("b2b_end_busy", busy, 0);
        chk("b2b_end_ready", s_ready, 1);
        tick();

        // Divisor change during DATA affects only the next frame
        baud_div = 16'd9;
        rw[0] = 8'h5A;
        rw[1] = 8'hC3;
        fork
            begin
                check_frame(rw[0], 9, 2'b00, 1'b0, "cfg_a", w);
                check_frame(rw[1], 4, 2'b00, 1'b0, "cfg_b", w);
                chk("cfg_b_gap", w, 0);
            end
            begin
                push(rw[0]);
                push(rw[1]);
                repeat (30) tick();
                baud_div = 16'd4;
            end
        join
        tick();

        // Reset during DATA with three words queued
        baud_div = 16'd9;
        push(8'h00);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (20) tick();
        chk("midrst_pre_level", fifo_level, 3);
        chk("midrst_pre_txd", uart_txd, 0);
        chk("midrst_pre_busy", busy, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_txd", uart_txd, 1);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", s_ready, 1);
        tick();
        tick();
        resetn = 1'b1;
        cnt = 0;
        repeat (200) begin
            tick();
            if (uart_txd === 1'b1 && busy === 1'b0) cnt++;
        end
        chk("midrst_no_residual", cnt, 200);

        // Randomised bursts with random configuration
        for (int r = 0; r < 6; r++) begin
            baud_div    = 16'($urandom_range(0, 3));
            parity_mode = 2'($urandom_range(0, 3));
            stop2       = 1'($urandom_range(0, 1));
            run_burst($urandom_range(1, 4), $sformatf("rnd%0d", r));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised, FIFO-buffered UART transmitter. It is the successor to the fixed-format 8N1 transmitter model and is used in the verification library as the serial driver for DUT receive pins. It accepts payload words over a valid/ready handshake into an internal FIFO. Frames are emitted back-to-back, with the baud divisor, parity mode and stop-bit count set at run time.

## Interface
- PAYLOAD_BITS, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- DIV_W, 16, width of the baud divisor input.
- LVL_W, $clog2(FIFO_DEPTH+1), width of fifo_level.

- clk  input  1  system clock.
- resetn  input  1  reset, asynchronous, active-low.
- s_valid  input  1  payload word offered.
- s_ready  output  1  FIFO can accept; equals !full.
- s_data  input  PAYLOAD_BITS  payload word.
- baud_div  input  DIV_W  bit period minus one, in clk cycles.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  input  1  0: one stop bit; 1: two stop bits.
- uart_txd  output  1  serial line, registered, idle high.
- busy  output  1  high when the FSM is not IDLE or fifo_level != 0.
- tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.
- fifo_level  output  LVL_W  current FIFO occupancy.

## Operation
- FIFO write occurs when s_valid && s_ready at a rising edge. Data offered while s_ready is low is not taken, and s_valid may stay asserted.
- FIFO read (pop) occurs only in IDLE, or at the end of the last stop bit, when fifo_level != 0.
- On pop:
  - load the shift register with the popped word.
  - latch baud_div, parity_mode and stop2 into frame-config registers.
  - compute and latch the parity bit: even = XOR of the data bits; odd = inverted XOR.
  - enter START.
- Run-time inputs are sampled only at pop. Changes during a frame take effect from the next frame.
- FSM states:
  - IDLE: txd = 1. Goes to START on pop.
  - START: txd = 0 for one bit period, then DATA.
  - DATA: txd = shift_reg[0], LSB first. The register shifts right at each bit end. After PAYLOAD_BITS bits, goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: txd = the latched parity bit for one bit period, then STOP.
  - STOP: txd = 1 for 1 or 2 bit periods, then pulse tx_done. Pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Bit period is (latched baud_div + 1) cycles. A cycle counter counts 0..baud_div and clears at each bit end. baud_div = 0 gives a 1-cycle bit.
- Frame length is (1 + PAYLOAD_BITS + P + S) × (baud_div + 1) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- FIFO pointers use an extra wrap bit, giving full/empty without a separate flag.
  - On the same edge, a push when full is impossible because s_ready = 0.
  - A pop when empty is prevented.
  - A simultaneous push and pop leaves fifo_level unchanged.

## Timing
- Reset values (asynchronous, applied immediately):
  - uart_txd = 1, s_ready = 1, busy = 0, tx_done = 0, fifo_level = 0.
  - FSM = IDLE, FIFO pointers = 0.
- Reset asserted mid-frame: the line returns high at once, and the FIFO contents and the frame in flight are discarded.
- No fall-through. A word accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. uart_txd goes low from edge N+1.
- fifo_level updates on the edge following the push or pop. s_ready drops on the edge where the FIFO becomes full.
- uart_txd changes only on bit-end edges and on the pop edge. It is glitch-free because it is driven from a register.
- Back-to-back frames: the next START begins on the same edge that ends the last stop bit, so the line has no idle gap.
- tx_done is high for the cycle ending the last stop bit. It is asserted whether or not a following frame starts.

## Test plan
- Reset: hold resetn low and drive s_valid → uart_txd = 1, s_ready = 1, fifo_level = 0, busy = 0. Deassert reset → no frame emitted.
- 8N1 with baud_div = 9, push 0xA5 → start bit low for 10 cycles, then bits 1,0,1,0,0,1,0,1. Stop bit high for 10 cycles, tx_done pulses at cycle 100 after the fall, busy then low.
- Parity/stop: parity_mode = 01, stop2 = 1, push 0x07 → parity bit 1 and two stop bits, frame 120 cycles. Repeat with parity_mode = 10 → parity bit 0.
- FIFO full and back-to-back with FIFO_DEPTH = 16: push 17 words at full rate → s_ready low after the 16th stored word (one already popped allows 17 to be accepted). All words are emitted in order with no idle gap between frames, and fifo_level returns to 0.
- Config change mid-frame: change baud_div from 9 to 4 during DATA → the current frame keeps 10-cycle bits and the next frame uses 5-cycle bits.
- Reset mid-frame: assert resetn low during DATA with 3 words queued → uart_txd high immediately and fifo_level = 0. After release, no residual frame is emitted.
